// File: rtl/isa_pkg.sv
// ============================================================================
// Module      : isa_pkg
// Description : Operation enum, MIPS opcode/funct tables, encoder FSM states
//               and word-packing helpers shared with the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

    typedef enum logic [4:0] {
        ADD  = 5'd0,
        SUB  = 5'd1,
        AND  = 5'd2,
        OR   = 5'd3,
        SLT  = 5'd4,
        XOR  = 5'd5,
        NOR  = 5'd6,
        SLL  = 5'd7,
        SRL  = 5'd8,
        JR   = 5'd9,
        ADDI = 5'd10,
        ORI  = 5'd11,
        XORI = 5'd12,
        ANDI = 5'd13,
        SLTI = 5'd14,
        LW   = 5'd15,
        SW   = 5'd16,
        BEQ  = 5'd17,
        BNE  = 5'd18,
        J    = 5'd19,
        JAL  = 5'd20,
        NOP  = 5'd21,
        BLTZ = 5'd22,
        BGEZ = 5'd23,
        SGT  = 5'd24
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OUT   = 2'd1,
        S_PAIR1 = 2'd2
    } state_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_field_pack.sv
// ============================================================================
// Module      : instr_field_pack
// Description : Combinational descriptor-to-word packer. Pseudo-op expansion
//               (bltz/bgez/sgt) is built only when PSEUDO_EXPAND_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_pack
    import isa_pkg::*;
#(
    parameter int AT_REG = 1
) (
    input  logic [4:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word0_o,
    output logic [31:0] word1_o,
    output logic        two_word_o,
    output logic        illegal_o
);

`ifdef PSEUDO_EXPAND_EN
    localparam logic [4:0] AT = 5'(AT_REG);
`endif

    always_comb begin
        word0_o    = '0;
        word1_o    = '0;
        two_word_o = 1'b0;
        illegal_o  = 1'b0;
        // shamt only reaches the word for shifts; shifts and jr zero their unused register fields
        case (op_i)
            ADD:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            SUB:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            AND:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            OR:   word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            SLT:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
            XOR:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            NOR:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
            SLL:  word0_o = enc_r(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
            SRL:  word0_o = enc_r(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
            JR:   word0_o = enc_r(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            ADDI: word0_o = enc_i(OPC_ADDI, rs_i, rt_i, imm_i);
            ORI:  word0_o = enc_i(OPC_ORI,  rs_i, rt_i, imm_i);
            XORI: word0_o = enc_i(OPC_XORI, rs_i, rt_i, imm_i);
            ANDI: word0_o = enc_i(OPC_ANDI, rs_i, rt_i, imm_i);
            SLTI: word0_o = enc_i(OPC_SLTI, rs_i, rt_i, imm_i);
            LW:   word0_o = enc_i(OPC_LW,   rs_i, rt_i, imm_i);
            SW:   word0_o = enc_i(OPC_SW,   rs_i, rt_i, imm_i);
            BEQ:  word0_o = enc_i(OPC_BEQ,  rs_i, rt_i, imm_i);
            BNE:  word0_o = enc_i(OPC_BNE,  rs_i, rt_i, imm_i);
            J:    word0_o = enc_j(OPC_J,   target_i);
            JAL:  word0_o = enc_j(OPC_JAL, target_i);
            NOP:  word0_o = 32'h0000_0000;
`ifdef PSEUDO_EXPAND_EN
            BLTZ: begin
                word0_o    = enc_r(rs_i, 5'd0, AT, 5'd0, FN_SLT);
                word1_o    = enc_i(OPC_BNE, AT, 5'd0, imm_i);
                two_word_o = 1'b1;
            end
            BGEZ: begin
                word0_o    = enc_r(rs_i, 5'd0, AT, 5'd0, FN_SLT);
                word1_o    = enc_i(OPC_BEQ, AT, 5'd0, imm_i);
                two_word_o = 1'b1;
            end
            SGT:  word0_o = enc_r(rt_i, rs_i, rd_i, 5'd0, FN_SLT);
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Handshaked descriptor-to-MIPS-word encoder with address stamp
//               and illegal-op reporting. PSEUDO_EXPAND_EN builds two-word ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int AT_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              addr_clr,
    output logic              err,
    output logic [7:0]        err_count
);

    logic [31:0] pk_word0;
    logic [31:0] pk_word1;
    logic        pk_two;
    logic        pk_illegal;

    instr_field_pack #(
        .AT_REG(AT_REG)
    ) u_pack (
        .op_i       (in_op),
        .rs_i       (in_rs),
        .rt_i       (in_rt),
        .rd_i       (in_rd),
        .shamt_i    (in_shamt),
        .imm_i      (in_imm),
        .target_i   (in_target),
        .word0_o    (pk_word0),
        .word1_o    (pk_word1),
        .two_word_o (pk_two),
        .illegal_o  (pk_illegal)
    );

    state_e             state_q, state_d;
    logic [31:0]        word_q, word_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               err_q;
    logic [7:0]         errcnt_q;
    logic               accept;
    logic               load;
    logic               out_hs;

`ifdef PSEUDO_EXPAND_EN
    logic [31:0]        word1_q, word1_d;
`else
    logic               unused_pair;
    assign unused_pair = &{1'b0, pk_word1, pk_two};
`endif

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && !pk_illegal;
    assign out_valid = (state_q != S_IDLE);
    assign out_hs    = out_valid && out_ready;

    assign out_word  = word_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign err_count = errcnt_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
`ifdef PSEUDO_EXPAND_EN
        word1_d = word1_q;
`endif
        case (state_q)
            // in_ready covers both idle and a draining S_OUT, so one path loads either
            S_IDLE, S_OUT: begin
                if (in_ready) begin
                    if (load) begin
                        word_d  = pk_word0;
                        state_d = S_OUT;
`ifdef PSEUDO_EXPAND_EN
                        if (pk_two) begin
                            word1_d = pk_word1;
                            state_d = S_PAIR1;
                        end
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef PSEUDO_EXPAND_EN
            S_PAIR1: begin
                if (out_ready) begin
                    word_d  = word1_q;
                    state_d = S_OUT;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
`ifdef PSEUDO_EXPAND_EN
            word1_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
`ifdef PSEUDO_EXPAND_EN
            word1_q <= word1_d;
`endif
            if (addr_clr) begin
                addr_q <= '0;
            end else if (out_hs) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            err_q <= accept && pk_illegal;
            if (accept && pk_illegal && (errcnt_q != 8'hFF)) begin
                errcnt_q <= errcnt_q + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Scoreboard bench for instr_encoder; pseudo-op expectations
//               follow PSEUDO_EXPAND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;
    import isa_pkg::*;

    typedef struct packed {
        logic [31:0] w;
        logic [7:0]  a;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
    logic        addr_clr;
    logic        err;
    logic [7:0]  err_count;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [7:0]  nxt_addr;
    logic [7:0]  exp_ecnt;
    int          w;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W(8),
        .AT_REG(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .addr_clr  (addr_clr),
        .err       (err),
        .err_count (err_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] word);
        sb.push_back('{w: word, a: nxt_addr});
        nxt_addr = nxt_addr + 8'd1;
    endtask

    // Presents one descriptor and returns just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, output int waits);
        @(negedge clk);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt; in_valid = 1'b1;
        waits = 0;
        forever begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                break;
            end
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h at addr %0d, expected none", out_word, out_addr);
                end else begin
                    e = sb.pop_front();
                    chk("out_word", out_word, e.w);
                    chk("out_addr", {24'b0, out_addr}, {24'b0, e.a});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_shamt = '0; in_imm = '0; in_target = '0; out_ready = 1'b1; addr_clr = 1'b0;
        nxt_addr = 8'd0; exp_ecnt = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_word",  out_word,           32'd0);
        chk("rst_out_addr",  {24'b0, out_addr},  32'd0);
        chk("rst_err",       {31'b0, err},       32'd0);
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Native encodings, back-to-back after the first
        push(32'h00221820); send(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w);
        idle_cycles(2);
        push(32'h2008FFFF); send(ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, w);
        push(32'h08000010); send(J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, w);
        chk("j_no_bubble", w, 0);
        push(32'h000628C0); send(SLL, 5'd7, 5'd6, 5'd5, 5'd3, 16'h0, 26'h0, w);
        push(32'h03E00008); send(JR, 5'd31, 5'd5, 5'd5, 5'd9, 16'h0, 26'h0, w);
        push(32'h00000000); send(NOP, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 26'h5, w);
        push(32'hAFA40010); send(SW, 5'd29, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, w);
        push(32'h00221822); send(SUB, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, w);
        idle_cycles(3);

`ifdef PSEUDO_EXPAND_EN
        push(32'h0041182A); send(SGT, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w);
        idle_cycles(3);
        @(negedge clk) out_ready = 1'b0;
        push(32'h0080082A); push(32'h14200003);
        send(BLTZ, 5'd4, 5'd0, 5'd0, 5'd0, 16'd3, 26'h0, w);
        for (int i = 0; i < 5; i++) begin
            chk("bltz_stall_word", out_word, 32'h0080082A);
            chk("bltz_in_ready",   {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk) out_ready = 1'b1;
        idle_cycles(4);
`else
        send(SGT, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w);
        chk("sgt_illegal_err", {31'b0, err}, 32'd1);
        exp_ecnt = exp_ecnt + 8'd1;
        send(BLTZ, 5'd4, 5'd0, 5'd0, 5'd0, 16'd3, 26'h0, w);
        chk("bltz_illegal_err", {31'b0, err}, 32'd1);
        exp_ecnt = exp_ecnt + 8'd1;
        idle_cycles(3);
`endif

        // Illegal op handling and counter saturation
        send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, w);
        exp_ecnt = exp_ecnt + 8'd1;
        chk("illegal_err",       {31'b0, err},       32'd1);
        chk("illegal_err_count", {24'b0, err_count}, {24'b0, exp_ecnt});
        chk("illegal_no_valid",  {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("illegal_err_pulse", {31'b0, err}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            send(5'(25 + (i % 7)), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, w);
        end
        idle_cycles(1);
        chk("err_count_sat", {24'b0, err_count}, 32'd255);

        // Address wrap through 255 -> 0
        @(negedge clk) addr_clr = 1'b1;
        @(negedge clk) addr_clr = 1'b0;
        nxt_addr = 8'd0;
        chk("addr_clr_idle", {24'b0, out_addr}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            push(32'h0); send(NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, w);
        end
        push(32'h00221820); send(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w);
        idle_cycles(3);

        // addr_clr in the same cycle as a handshake
        push(32'h00221820); send(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w);
        @(negedge clk) addr_clr = 1'b1;
        @(posedge clk);
        #1 addr_clr = 1'b0;
        nxt_addr = 8'd0;
        chk("addr_clr_vs_hs", {24'b0, out_addr}, 32'd0);
        push(32'h2008FFFF); send(ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, w);
        idle_cycles(3);

        // Reset while a word is pending (second pseudo word when enabled)
        @(negedge clk) out_ready = 1'b0;
`ifdef PSEUDO_EXPAND_EN
        send(BGEZ, 5'd4, 5'd0, 5'd0, 5'd0, 16'd3, 26'h0, w);
        chk("bgez_word0", out_word, 32'h0080082A);
`else
        send(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w);
        chk("pend_word0", out_word, 32'h00221820);
`endif
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("midrst_err_count", {24'b0, err_count}, 32'd0);
        @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
        nxt_addr = 8'd0;
        idle_cycles(3);
        chk("midrst_idle_valid", {31'b0, out_valid}, 32'd0);
        push(32'h00221820); send(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, w);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        idle_cycles(1);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder side of the instruction decode path. Accepts one abstract operation descriptor per handshake and emits the 32-bit MIPS machine word(s) that the control unit decodes back into the same operation.
- Expands the pseudo-instructions bltz, bgez and sgt into native words.
- Stamps each emitted word with an instruction-memory write address.
- Sits between the program-load/self-test source and instruction memory.

Parameters:
ADDR_W, 8, width of the emitted-word address counter
AT_REG, 1, register index used as scratch ($at) in pseudo expansion

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid&&in_ready
in_op  in  5  operation enum (package op_e)
in_rs  in  5  source register
in_rt  in  5  second source / I-type destination
in_rd  in  5  R-type destination
in_shamt  in  5  shift amount (sll/srl only)
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target
out_valid  out  1  word valid
out_ready  in  1  word consumed when out_valid&&out_ready
out_word  out  32  encoded instruction
out_addr  out  ADDR_W  address of out_word
addr_clr  in  1  synchronous clear of address counter
err  out  1  one-cycle pulse on illegal op
err_count  out  8  saturating illegal-op count

Behaviour:
- Reset (rst_n=0 at clk edge), outputs and state:
  - state=S_IDLE
  - out_valid=0, out_word=0, out_addr=0
  - err=0, err_count=0
  - pending second word cleared
  - Reset mid-pair discards the second word.
- Encodings:
  - R-type: {6'h00,rs,rt,rd,shamt,funct}
  - I-type: {op,rs,rt,imm}
  - J-type: {op,target}
- Opcodes: addi 08, andi 0C, ori 0D, xori 0E, slti 0A, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03.
- Functs: add 20, sub 22, and 24, or 25, xor 26, nor 27, slt 2A, sll 00, srl 02, jr 08.
- Field forcing:
  - shamt is forced to 0 except for sll/srl.
  - sll/srl force rs=0.
  - jr forces rt=rd=shamt=0.
  - nop encodes as 32'h0.
- Pseudo expansion ($at=AT_REG):
  - bltz rs,imm -> slt $at,rs,$0 ; bne $at,$0,imm
  - bgez rs,imm -> slt $at,rs,$0 ; beq $at,$0,imm
  - sgt rd,rs,rt -> slt rd,rt,rs (single word)
  - imm passes unchanged; the program source has already computed the offset relative to the second word.
- FSM states:
  - S_IDLE: out_valid=0, in_ready=1. On accept of a legal op: load out_word, set out_valid. Go to S_OUT, or S_PAIR1 if the op is a two-word pseudo (second word latched).
  - S_OUT: out_valid=1. On out_ready: if a new descriptor is accepted in the same cycle, load it (back-to-back, no bubble); else go to S_IDLE.
  - S_PAIR1: out_valid=1, in_ready=0. On out_ready: load the latched second word and go to S_OUT.
- in_ready = S_IDLE || (S_OUT && out_ready). Combinational on out_ready.
- Latency: descriptor accepted at edge N -> out_valid=1 from edge N. out_word is stable while out_valid=1 and out_ready=0.
- out_addr:
  - Increments by 1 on each out handshake; wraps 2^ADDR_W-1 -> 0.
  - addr_clr forces 0 and takes priority over increment in the same cycle.
- Illegal op (enum value > 24):
  - Descriptor consumed, no word emitted, state unchanged (S_IDLE or back to S_IDLE).
  - err=1 for exactly one cycle.
  - err_count increments and saturates at 255.

Optional Feature:
- PSEUDO_EXPAND_EN defined: bltz/bgez/sgt expand as above.
- PSEUDO_EXPAND_EN undefined: those enum values are illegal (err path). S_PAIR1 and the second-word register are not built. in_ready = S_IDLE || (S_OUT && out_ready) still holds.

Decomposition:
- Package isa_pkg:
  - op_e enum: ADD=0,SUB,AND,OR,SLT,XOR,NOR,SLL,SRL,JR,ADDI,ORI,XORI,ANDI,SLTI,LW,SW,BEQ,BNE,J,JAL,NOP,BLTZ,BGEZ,SGT=24
  - opcode/funct localparams, shared with the control unit
  - state enum
- Sub-module instr_field_pack: combinational descriptor -> {word0, word1, two_word, illegal}. Keeps the FSM file free of encoding tables.

Test Plan:
- add rd=3,rs=1,rt=2, out_ready=1 -> out_word=32'h00221820, out_addr=0, next accept gives out_addr=1.
- addi rt=8,rs=0,imm=16'hFFFF then j target=26'h10 back-to-back -> 32'h2008FFFF then 32'h08000010 on consecutive cycles, no bubble.
- bltz rs=4,imm=3 (PSEUDO_EXPAND_EN) -> 32'h0080082A then 32'h14200003, in_ready=0 between them. With out_ready held 0 for 5 cycles, word0 is stable and word1 is not lost.
- in_op=31 -> no out_valid, err pulses 1 cycle, err_count=1. 256 illegal ops -> err_count stays 255.
- out_addr preset to 255 by 255 handshakes, then one more -> 0. addr_clr coincident with a handshake -> 0.
- rst_n=0 while in S_PAIR1 -> next cycle out_valid=0, in_ready=1, second word never emitted.
